// File: rtl/lock_monitor_pkg.sv
// lock_monitor_pkg
// Shared definitions for the out-of-lock detector: FSM state encodings,
// default widths and small dwell-counter helpers.
package lock_monitor_pkg;

    localparam int LM_R_DEFAULT  = 14;
    localparam int LM_CW_DEFAULT = 16;

    typedef enum logic [2:0] {
        LM_IDLE     = 3'd0,
        LM_LOCKED   = 3'd1,
        LM_SUSPECT  = 3'd2,
        LM_UNLOCKED = 3'd3,
        LM_CONFIRM  = 3'd4
    } lm_state_e;

    // True when one more qualifying cycle makes the dwell count reach the
    // programmed time exactly. Evaluated one bit wider so an all-ones count
    // can never alias to a small target.
    function automatic logic dwell_hits(input logic [31:0] cnt,
                                        input logic [31:0] target);
        return (({1'b0, cnt} + 33'd1) == {1'b0, target});
    endfunction

    // Dwell counter advance that holds at all-ones instead of wrapping.
    function automatic logic [31:0] dwell_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : (cnt + 32'd1);
    endfunction

endpackage

// File: rtl/lock_monitor_window_cmp.sv
// lock_window_cmp
// Registered signed window comparator for the lock-quality signal.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sig_in              signed monitored signal
//   low_th, hig_th      signed inclusive window limits
//   in_window           registered (low_th <= sig_in <= hig_th)
// An inverted window (low_th > hig_th) can never be satisfied, so it
// naturally yields in_window = 0 without a separate check.
module lock_window_cmp #(
    parameter int R = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [R-1:0] sig_in,
    input  logic signed [R-1:0] low_th,
    input  logic signed [R-1:0] hig_th,
    output logic                in_window
);

    // Registered signed window comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_window <= 1'b0;
        end else begin
            in_window <= (sig_in >= low_th) && (sig_in <= hig_th);
        end
    end

endmodule

// File: rtl/lock_monitor.sv
// lock_monitor
// Out-of-lock detector for the scanning ramp's relock path. A registered
// window comparison feeds a dwell-time debounce FSM with separate unlock
// and relock dwell times; out_of_lock is the FSM's verdict. Lock-loss
// events are counted (saturating) for the register bank.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   sig_in, low_th, hig_th    signed monitored signal and window limits
//   unlock_time, relock_time  dwell times in cycles (0 behaves as 1)
//   enable                    0 forces IDLE
//   clear                     synchronous clear of loss_count
//   in_window                 registered window comparison
//   out_of_lock               to ramp generator
//   lock_lost, lock_acq       one-cycle pulses on the edge out_of_lock changes
//   loss_count                saturating lock-loss event count
//   state                     FSM state readback
module lock_monitor
    import lock_monitor_pkg::*;
#(
    parameter int R  = LM_R_DEFAULT,
    parameter int CW = LM_CW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [R-1:0] sig_in,
    input  logic signed [R-1:0] low_th,
    input  logic signed [R-1:0] hig_th,
    input  logic [31:0]         unlock_time,
    input  logic [31:0]         relock_time,
    input  logic                enable,
    input  logic                clear,
    output logic                in_window,
    output logic                out_of_lock,
    output logic                lock_lost,
    output logic                lock_acq,
    output logic [CW-1:0]       loss_count,
    output logic [2:0]          state
);

    lm_state_e   fsm_state;
    logic [31:0] cnt;

    lock_window_cmp #(
        .R(R)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .low_th    (low_th),
        .hig_th    (hig_th),
        .in_window (in_window)
    );

    assign state = fsm_state;

    // Dwell FSM, its pulses and the loss counter; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_state   <= LM_IDLE;
            cnt         <= 32'd0;
            out_of_lock <= 1'b0;
            lock_lost   <= 1'b0;
            lock_acq    <= 1'b0;
            loss_count  <= {CW{1'b0}};
        end else begin
            lock_lost <= 1'b0;
            lock_acq  <= 1'b0;

            if (!enable) begin
                fsm_state   <= LM_IDLE;
                cnt         <= 32'd0;
                out_of_lock <= 1'b0;
            end else begin
                case (fsm_state)
                    LM_IDLE: begin
                        fsm_state   <= LM_LOCKED;
                        cnt         <= 32'd0;
                        out_of_lock <= 1'b0;
                    end

                    LM_LOCKED: begin
                        if (!in_window) begin
                            // A dwell of 0 or 1 declares unlock on the first bad sample.
                            if (unlock_time <= 32'd1) begin
                                fsm_state   <= LM_UNLOCKED;
                                cnt         <= 32'd0;
                                out_of_lock <= 1'b1;
                                lock_lost   <= 1'b1;
                                if (loss_count != {CW{1'b1}}) begin
                                    loss_count <= loss_count + {{(CW-1){1'b0}}, 1'b1};
                                end
                            end else begin
                                fsm_state <= LM_SUSPECT;
                                cnt       <= 32'd1;
                            end
                        end
                    end

                    LM_SUSPECT: begin
                        if (in_window) begin
                            fsm_state <= LM_LOCKED;
                            cnt       <= 32'd0;
                        end else if (dwell_hits(cnt, unlock_time)) begin
                            fsm_state   <= LM_UNLOCKED;
                            cnt         <= 32'd0;
                            out_of_lock <= 1'b1;
                            lock_lost   <= 1'b1;
                            if (loss_count != {CW{1'b1}}) begin
                                loss_count <= loss_count + {{(CW-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            // Exact match only: a time lowered below cnt keeps us here.
                            cnt <= dwell_inc(cnt);
                        end
                    end

                    LM_UNLOCKED: begin
                        if (in_window) begin
                            // out_of_lock falls here, so lock_acq marks this edge too.
                            if (relock_time <= 32'd1) begin
                                fsm_state   <= LM_LOCKED;
                                cnt         <= 32'd0;
                                out_of_lock <= 1'b0;
                                lock_acq    <= 1'b1;
                            end else begin
                                fsm_state <= LM_CONFIRM;
                                cnt       <= 32'd1;
                            end
                        end
                    end

                    LM_CONFIRM: begin
                        if (!in_window) begin
                            // Failed relock attempt: not a new loss event.
                            fsm_state <= LM_UNLOCKED;
                            cnt       <= 32'd0;
                        end else if (dwell_hits(cnt, relock_time)) begin
                            fsm_state   <= LM_LOCKED;
                            cnt         <= 32'd0;
                            out_of_lock <= 1'b0;
                            lock_acq    <= 1'b1;
                        end else begin
                            cnt <= dwell_inc(cnt);
                        end
                    end

                    default: begin
                        fsm_state   <= LM_IDLE;
                        cnt         <= 32'd0;
                        out_of_lock <= 1'b0;
                    end
                endcase
            end

            // Clear overrides a same-cycle increment.
            if (clear) begin
                loss_count <= {CW{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_lock_monitor.sv
// tb_lock_monitor
// Directed and randomized stimulus for lock_monitor, checked every cycle
// against a run-length reference model of the dwell rules.
module tb_lock_monitor;

    localparam int R  = 14;
    localparam int CW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic                clk;
    logic                rst;
    logic signed [R-1:0] sig_in;
    logic signed [R-1:0] low_th;
    logic signed [R-1:0] hig_th;
    logic [31:0]         unlock_time;
    logic [31:0]         relock_time;
    logic                enable;
    logic                clear;
    logic                in_window;
    logic                out_of_lock;
    logic                lock_lost;
    logic                lock_acq;
    logic [CW-1:0]       loss_count;
    logic [2:0]          state;

    int tests;
    int fails;

    // stimulus as plain integers
    int s_sig, s_low, s_hig;

    // reference model: verdict, length of the current run of contrary evidence
    bit     m_inw, m_idle, m_ool, m_lost, m_acq;
    longint m_run;
    int     m_cnt;

    lock_monitor #(.R(R), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .low_th      (low_th),
        .hig_th      (hig_th),
        .unlock_time (unlock_time),
        .relock_time (relock_time),
        .enable      (enable),
        .clear       (clear),
        .in_window   (in_window),
        .out_of_lock (out_of_lock),
        .lock_lost   (lock_lost),
        .lock_acq    (lock_acq),
        .loss_count  (loss_count),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        sig_in = s_sig[R-1:0];
        low_th = s_low[R-1:0];
        hig_th = s_hig[R-1:0];
    endtask

    task automatic model_reset();
        m_inw = 1'b0; m_idle = 1'b1; m_ool = 1'b0;
        m_lost = 1'b0; m_acq = 1'b0; m_run = 0; m_cnt = 0;
    endtask

    function automatic int model_state();
        if (m_idle) return 0;
        if (!m_ool) return (m_run == 0) ? 1 : 2;
        return (m_run == 0) ? 3 : 4;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_in_window"}, {31'd0, in_window}, {31'd0, m_inw});
        check({tag, "_out_of_lock"}, {31'd0, out_of_lock}, {31'd0, m_ool});
        check({tag, "_lock_lost"}, {31'd0, lock_lost}, {31'd0, m_lost});
        check({tag, "_lock_acq"}, {31'd0, lock_acq}, {31'd0, m_acq});
        check({tag, "_loss_count"}, {30'd0, loss_count}, m_cnt);
        check({tag, "_state"}, {29'd0, state}, model_state());
    endtask

    // One clock edge: advance the model with the inputs held across it, then compare.
    task automatic tick(input string tag);
        bit     nin, bad;
        longint need, eff;
        drive();
        @(posedge clk);
        nin = (s_sig >= s_low) && (s_sig <= s_hig);
        m_lost = 1'b0;
        m_acq  = 1'b0;
        if (!enable) begin
            m_idle = 1'b1; m_ool = 1'b0; m_run = 0;
        end else if (m_idle) begin
            m_idle = 1'b0; m_run = 0;
        end else begin
            bad = m_ool ? m_inw : !m_inw;
            if (!bad) begin
                m_run = 0;
            end else begin
                need = m_ool ? longint'(relock_time) : longint'(unlock_time);
                eff  = (m_run == 0 && need == 0) ? 1 : need;
                if (m_run + 1 == eff) begin
                    m_ool = !m_ool;
                    m_run = 0;
                    if (m_ool) m_lost = 1'b1;
                    else       m_acq  = 1'b1;
                end else begin
                    m_run++;
                end
            end
        end
        if (clear) m_cnt = 0;
        else if (m_lost && m_cnt < CMAX) m_cnt++;
        m_inw = nin;
        #1;
        check_all(tag);
    endtask

    initial begin
        bit phase;
        tests = 0; fails = 0;
        rst = 1'b1; enable = 1'b1; clear = 1'b0;
        s_sig = 0; s_low = -100; s_hig = 100;
        unlock_time = 32'd5; relock_time = 32'd10;
        drive();
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;
        repeat (3) tick("settle");
        check("t0_locked_state", {29'd0, state}, 32'd1);

        // Unlock after exactly 5 out-of-window samples.
        s_sig = 300;
        repeat (5) tick("t1_dwell");
        check("t1_ool_pre", {31'd0, out_of_lock}, 32'd0);
        tick("t1_edge");
        check("t1_ool", {31'd0, out_of_lock}, 32'd1);
        check("t1_lost", {31'd0, lock_lost}, 32'd1);
        check("t1_count", {30'd0, loss_count}, 32'd1);

        // Relock attempt at the inclusive edge, interrupted by a dip.
        s_sig = 100;
        repeat (7) tick("t3_confirm");
        s_sig = 300;
        repeat (2) tick("t3_dip");
        check("t3_dip_state", {29'd0, state}, 32'd3);
        check("t3_dip_count", {30'd0, loss_count}, 32'd1);

        // Full relock: out_of_lock falls exactly 10 edges after in_window rises.
        s_sig = 100;
        repeat (10) tick("t3_relock");
        check("t3_ool_pre", {31'd0, out_of_lock}, 32'd1);
        tick("t3_edge");
        check("t3_acq", {31'd0, lock_acq}, 32'd1);
        check("t3_ool", {31'd0, out_of_lock}, 32'd0);

        // Short excursion: SUSPECT back to LOCKED without unlock.
        s_sig = 300;
        repeat (4) tick("t2_out");
        s_sig = 0;
        repeat (3) tick("t2_back");
        check("t2_state", {29'd0, state}, 32'd1);
        check("t2_count", {30'd0, loss_count}, 32'd1);

        // Zero dwell behaves as one.
        unlock_time = 32'd0;
        s_sig = 300;
        tick("t4_sample");
        s_sig = 0;
        tick("t4_edge");
        check("t4_state", {29'd0, state}, 32'd3);

        // Inverted window never matches.
        s_low = 50; s_hig = -50;
        repeat (4) tick("t4_inv");
        check("t4_inv_win", {31'd0, in_window}, 32'd0);

        // Saturating loss counter with 1-cycle dwells.
        s_low = -100; s_hig = 100;
        unlock_time = 32'd1; relock_time = 32'd1;
        repeat (2) tick("t5_relock");
        clear = 1'b1;
        tick("t5_clear");
        clear = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            s_sig = 300;
            repeat (2) tick("t5_loss");
            check("t5_sat_count", {30'd0, loss_count}, (k > CMAX) ? CMAX : k);
            s_sig = 0;
            repeat (2) tick("t5_acq");
        end
        s_sig = 300;
        tick("t5_fifth");
        clear = 1'b1;
        tick("t5_clear_win");
        clear = 1'b0;
        check("t5_clear_lost", {31'd0, lock_lost}, 32'd1);
        check("t5_clear_count", {30'd0, loss_count}, 32'd0);

        // Asynchronous reset in the middle of SUSPECT.
        s_sig = 0;
        repeat (2) tick("t6_lock");
        unlock_time = 32'd20;
        s_sig = 300;
        repeat (3) tick("t6_suspect");
        check("t6_suspect_state", {29'd0, state}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t6_async_rst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        unlock_time = 32'd2;
        repeat (6) tick("t6_unlock");
        check("t6_unlocked", {29'd0, state}, 32'd3);

        // enable dropped while in CONFIRM.
        relock_time = 32'd10;
        s_sig = 0;
        repeat (3) tick("t7_confirm");
        check("t7_confirm_state", {29'd0, state}, 32'd4);
        enable = 1'b0;
        tick("t7_disable");
        check("t7_idle", {29'd0, state}, 32'd0);
        check("t7_ool", {31'd0, out_of_lock}, 32'd0);
        enable = 1'b1;

        // Randomized traffic against the model.
        phase = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) phase = !phase;
            if ($urandom_range(0, 99) == 0) begin
                s_low = int'($urandom_range(0, 200)) - 150;
                s_hig = int'($urandom_range(0, 200)) - 50;
            end
            if ($urandom_range(0, 39) == 0) unlock_time = $urandom_range(0, 6);
            if ($urandom_range(0, 39) == 0) relock_time = $urandom_range(0, 6);
            enable = ($urandom_range(0, 59) != 0);
            clear  = ($urandom_range(0, 63) == 0);
            if (phase && s_low <= s_hig)
                s_sig = s_low + int'($urandom_range(0, s_hig - s_low));
            else
                s_sig = int'($urandom_range(0, 800)) - 400;
            tick("rand");
        end
        clear = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
